// File: rtl/irq_ctrl_if.sv
// Bundles the per-channel event/control vectors and the request/ack handshake
// between the interrupt controller and its producer/consumer.
interface irq_ctrl_if #(
  parameter int N_CH = 4
);
  localparam int ID_W = $clog2(N_CH);

  logic [N_CH-1:0] src_i;
  logic [N_CH-1:0] edge_mode_i;
  logic [N_CH-1:0] mask_i;
  logic [N_CH-1:0] clear_i;
  logic            irq_ack_i;
  logic            irq_req_o;
  logic [ID_W-1:0] irq_id_o;
  logic [N_CH-1:0] pending_o;
  logic [N_CH-1:0] overrun_o;

  modport master (
    output src_i, edge_mode_i, mask_i, clear_i, irq_ack_i,
    input  irq_req_o, irq_id_o, pending_o, overrun_o
  );

  modport slave (
    input  src_i, edge_mode_i, mask_i, clear_i, irq_ack_i,
    output irq_req_o, irq_id_o, pending_o, overrun_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt flag register and fixed-priority arbiter: sticky pending/overrun
// flags per channel, lowest enabled pending channel presented until acked.
//
//  state | meaning
//  IDLE  | no request outstanding; picks lowest enabled pending channel
//  REQ   | irq_req_o high, irq_id_o frozen until ack or withdrawal
module irq_ctrl #(
  parameter int N_CH = 4
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(N_CH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [N_CH-1:0] src_d;
  logic [N_CH-1:0] pending, pending_nxt;
  logic [N_CH-1:0] overrun, overrun_nxt;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] arb;
  logic [N_CH-1:0] ack_clr;
  logic [ID_W-1:0] irq_id, irq_id_nxt;
  logic [ID_W-1:0] low_id;

  assign ev  = (bus.edge_mode_i & bus.src_i & ~src_d) | (~bus.edge_mode_i & bus.src_i);
  assign arb = pending & bus.mask_i;

  always_comb begin
    low_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (arb[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    ack_clr    = '0;
    case (state)
      IDLE: begin
        if (|arb) begin
          irq_id_nxt = low_id;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over withdrawal so an acked id is always cleared.
        if (bus.irq_ack_i) begin
          ack_clr[irq_id] = 1'b1;
          state_nxt       = IDLE;
        end else if (!arb[irq_id]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending_nxt = pending;
    overrun_nxt = overrun;
    for (int i = 0; i < N_CH; i++) begin
      if (ev[i])                          pending_nxt[i] = 1'b1;
      else if (bus.clear_i[i] || ack_clr[i]) pending_nxt[i] = 1'b0;

      if (ev[i] && pending[i] && bus.edge_mode_i[i]) overrun_nxt[i] = 1'b1;
      else if (bus.clear_i[i])                       overrun_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      src_d   <= '0;
      pending <= '0;
      overrun <= '0;
      irq_id  <= '0;
    end else begin
      state   <= state_nxt;
      src_d   <= bus.src_i;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      irq_id  <= irq_id_nxt;
    end
  end

  assign bus.irq_req_o = (state == REQ);
  assign bus.irq_id_o  = irq_id;
  assign bus.pending_o = pending;
  assign bus.overrun_o = overrun;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus a random phase, all checked each cycle against a
// rule-level reference model of the flags and request.
module tb_irq_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_ctrl_if #(.N_CH(N)) bus ();
  irq_ctrl #(.N_CH(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_pend, m_ovr, m_srcd;
  bit           m_req;
  int           m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_srcd = '0; m_req = 0; m_id = 0;
  endtask

  // One clock of behaviour derived from the flag and handshake rules.
  task automatic model_clock();
    logic [N-1:0] ev, clr, en;
    bit           req_n;
    int           id_n;
    if (!rst) begin
      model_reset();
      return;
    end
    ev  = '0;
    clr = bus.clear_i;
    for (int i = 0; i < N; i++)
      ev[i] = bus.edge_mode_i[i] ? (bus.src_i[i] && !m_srcd[i]) : bus.src_i[i];
    en    = m_pend & bus.mask_i;
    req_n = m_req;
    id_n  = m_id;
    if (m_req) begin
      if (bus.irq_ack_i) begin
        clr[m_id] = 1'b1;
        req_n = 0;
      end else if (!en[m_id]) begin
        req_n = 0;
      end
    end else if (en != 0) begin
      req_n = 1;
      for (int i = N - 1; i >= 0; i--) if (en[i]) id_n = i;
    end
    m_ovr  = (m_ovr & ~bus.clear_i) | (ev & m_pend & bus.edge_mode_i);
    m_pend = (m_pend & ~clr) | ev;
    m_srcd = bus.src_i;
    m_req  = req_n;
    m_id   = id_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pending"}, 32'(bus.pending_o), 32'(m_pend));
    chk({tag, "_overrun"}, 32'(bus.overrun_o), 32'(m_ovr));
    chk({tag, "_req"}, 32'(bus.irq_req_o), 32'(m_req));
    if (m_req) chk({tag, "_id"}, 32'(bus.irq_id_o), 32'(m_id));
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    model_clock();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.src_i = '0; bus.edge_mode_i = '1; bus.mask_i = '1;
    bus.clear_i = '0; bus.irq_ack_i = 1'b0;
    model_reset();

    // 1: reset holds everything at zero regardless of sources
    for (int k = 0; k < 3; k++) begin
      bus.src_i = 4'(k * 5 + 3);
      cyc("t1_rst");
      chk("t1_req_zero", 32'(bus.irq_req_o), 0);
    end
    bus.src_i = '0;
    rst = 1'b1;
    cyc("t1_rel");
    cyc("t1_rel");

    // 2: single pulse on channel 2, then ack
    bus.src_i = 4'b0100;
    cyc("t2_ev");
    chk("t2_pend_set", 32'(bus.pending_o), 32'h4);
    chk("t2_req_not_yet", 32'(bus.irq_req_o), 0);
    bus.src_i = '0;
    cyc("t2_req");
    chk("t2_req", 32'(bus.irq_req_o), 1);
    chk("t2_id", 32'(bus.irq_id_o), 2);
    bus.irq_ack_i = 1'b1;
    cyc("t2_ack");
    chk("t2_req_drop", 32'(bus.irq_req_o), 0);
    chk("t2_pend_clr", 32'(bus.pending_o), 0);
    bus.irq_ack_i = 1'b0;
    cyc("t2_idle");

    // 3: simultaneous channels 1 and 3, priority then re-request
    bus.src_i = 4'b1010;
    cyc("t3_ev");
    bus.src_i = '0;
    cyc("t3_req1");
    chk("t3_id1", 32'(bus.irq_id_o), 1);
    bus.irq_ack_i = 1'b1;
    cyc("t3_ack1");
    chk("t3_gap", 32'(bus.irq_req_o), 0);
    bus.irq_ack_i = 1'b0;
    cyc("t3_req3");
    chk("t3_id3", 32'(bus.irq_id_o), 3);
    bus.irq_ack_i = 1'b1;
    cyc("t3_ack3");
    bus.irq_ack_i = 1'b0;
    cyc("t3_idle");

    // 4: overrun on channel 0, clear, then clear racing a new edge
    bus.src_i = 4'b0001; cyc("t4_e1");
    bus.src_i = '0;      cyc("t4_l1");
    bus.src_i = 4'b0001; cyc("t4_e2");
    chk("t4_ovr_set", 32'(bus.overrun_o[0]), 1);
    bus.src_i = '0;      cyc("t4_l2");
    bus.clear_i = 4'b0001; cyc("t4_clr");
    chk("t4_pend_clr", 32'(bus.pending_o[0]), 0);
    chk("t4_ovr_clr", 32'(bus.overrun_o[0]), 0);
    bus.clear_i = '0; cyc("t4_idle");
    bus.clear_i = 4'b0001; bus.src_i = 4'b0001; cyc("t4_race");
    chk("t4_set_wins", 32'(bus.pending_o[0]), 1);
    bus.clear_i = '0; bus.src_i = '0; cyc("t4_after");
    bus.irq_ack_i = 1'b1; cyc("t4_ack");
    bus.irq_ack_i = 1'b0; cyc("t4_end");

    // 5: masked pending, unmask to request, software clear withdraws
    bus.mask_i = 4'b1110;
    bus.src_i = 4'b0001; cyc("t5_ev");
    bus.src_i = '0;      cyc("t5_masked");
    chk("t5_no_req", 32'(bus.irq_req_o), 0);
    cyc("t5_masked2");
    bus.mask_i = 4'b1111; cyc("t5_unmask");
    chk("t5_req", 32'(bus.irq_req_o), 1);
    chk("t5_id0", 32'(bus.irq_id_o), 0);
    bus.clear_i = 4'b0001; cyc("t5_clr");
    bus.clear_i = '0;     cyc("t5_withdraw");
    chk("t5_withdrawn", 32'(bus.irq_req_o), 0);

    // 6: level channel 1 re-requests after ack; async reset mid-request
    bus.edge_mode_i = 4'b1101;
    bus.src_i = 4'b0010;
    cyc("t6_ev"); cyc("t6_req");
    chk("t6_id1", 32'(bus.irq_id_o), 1);
    bus.irq_ack_i = 1'b1; cyc("t6_ack");
    bus.irq_ack_i = 1'b0; cyc("t6_rereq");
    chk("t6_rereq_on", 32'(bus.irq_req_o), 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_async_req", 32'(bus.irq_req_o), 0);
    chk("t6_async_pend", 32'(bus.pending_o), 0);
    bus.src_i = '0;
    cyc("t6_inrst");
    rst = 1'b1;
    bus.edge_mode_i = '1;
    cyc("t6_rel");

    // Random phase
    for (int k = 0; k < 400; k++) begin
      bus.src_i       = 4'($urandom);
      bus.edge_mode_i = 4'($urandom);
      bus.mask_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bus.clear_i     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      bus.irq_ack_i   = 1'($urandom_range(0, 2) == 0);
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
